data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH from defs.vh (32), width of addr, wd and rd.
REQ-002 Parameter DEPTH, default 256, number of DATA_WIDTH-bit words stored; power of two.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low; sampled on rising clk edge.
REQ-005 addr  input  DATA_WIDTH  word index; bits [log2(DEPTH)-1:0] select the word, upper bits ignored.
REQ-006 wd  input  DATA_WIDTH  write data.
REQ-007 we  input  1  write enable, active-high.
REQ-008 MemRead  input  1  read enable, active-high.
REQ-009 rd  output  DATA_WIDTH  read data.
REQ-010 Port declaration order SHALL be addr, clk, wd, we, MemRead, rd, rst_n, so existing positional instantiations of six ports remain valid.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_WIDTH bits, word-addressed (addr 10 = word 10, not byte 10).
REQ-012 Write: on rising clk with rst_n=1 and we=1, mem[addr index] SHALL take wd; no other word changes.
REQ-013 Write latency: new value visible on rd immediately after the writing edge (same-cycle combinational read thereafter).
REQ-014 Read: combinational; rd SHALL equal mem[addr index] whenever MemRead=1, with no clock latency.
REQ-015 rd SHALL be all zeros whenever MemRead=0.
REQ-016 we=1 and MemRead=1 simultaneously: before the edge rd shows old contents; after the edge rd shows wd.
REQ-017 we=0: memory contents SHALL be unchanged on every edge.
REQ-018 Address aliasing: addresses differing only in ignored upper bits SHALL access the same word (wrap-around modulo DEPTH).
REQ-019 Addresses are not checked for range or alignment; no error output exists.
REQ-020 Word access only; no byte/halfword enables or sign extension.

Reset
REQ-021 On rising clk with rst_n=0, every memory word SHALL be cleared to zero.
REQ-022 Reset SHALL take priority over a simultaneous write (we=1 ignored in that cycle).
REQ-023 rd during/after reset follows REQ-014/015 (reads zero from any address).
REQ-024 Memory SHALL also initialize to all zeros at time zero (simulation/FPGA power-up), so unwritten words read zero even if rst_n is never asserted.
REQ-025 Reset asserted mid-operation SHALL discard all prior writes; writes resume the first edge after rst_n returns to 1.

Verification
REQ-026 rst_n=0 one edge, then rst_n=1, MemRead=1, addr=0..DEPTH-1 -> rd=0 for every address.
REQ-027 we=1, addr=10, wd=32'hDEADBEEF for one edge; then we=0, MemRead=1, addr=10 -> rd=32'hDEADBEEF; addr=20 -> rd=0.
REQ-028 After REQ-027 write, MemRead=0, addr=10 -> rd=0; MemRead=1 -> rd=32'hDEADBEEF without a clock edge.
REQ-029 we=1, MemRead=1, addr=5, mem[5]=0, wd=32'h12345678 -> rd=0 before edge, 32'h12345678 after edge.
REQ-030 Write 32'hA5A5A5A5 at addr=3, read addr=3+DEPTH -> rd=32'hA5A5A5A5 (alias).
REQ-031 Write 32'hCAFEF00D at addr=7, then rst_n=0 with we=1, addr=7, wd=32'h1 for one edge -> afterwards addr=7 reads 0.

Source files
------------

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read gated by MemRead, one write
// port clocked on the rising edge, synchronous active-low clear of every word.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module data_memory #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 256
) (
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  we,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] rd,
  input  logic                  rst_n
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Declaration initializer gives zeroed contents at power-up, before any reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [AW-1:0]         idx;

  // Upper address bits are ignored, so addresses alias modulo DEPTH.
  assign idx = addr[AW-1:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[DATA_WIDTH-1:AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wd;
    end
  end

  assign rd = MemRead ? mem[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: literal directed scenarios, then randomized traffic
// compared every cycle against an array model of the memory.
module tb_data_memory;

  localparam int W     = 32;
  localparam int DEPTH = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] addr = '0;
  logic [W-1:0] wd = '0;
  logic         we = 1'b0;
  logic         mem_read = 1'b0;
  logic [W-1:0] rd;

  data_memory #(.DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .addr(addr),
    .clk(clk),
    .wd(wd),
    .we(we),
    .MemRead(mem_read),
    .rd(rd),
    .rst_n(rst_n)
  );

  // clock / reset block: reset is driven explicitly by the stimulus
  always #5 clk = ~clk;

  // reference model: plain array indexed by address modulo DEPTH
  logic [W-1:0] model [DEPTH] = '{default: '0};
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (model[i]) model[i] = '0;
    end else if (we) begin
      model[addr % DEPTH] = wd;
    end
  end

  function automatic logic [W-1:0] expect_rd();
    return mem_read ? model[addr % DEPTH] : '0;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rd=%h expected=%h (addr=%h MemRead=%b t=%0t)", name, act, exp, addr, mem_read, $time);
    end
  endtask

  // scoreboard: compare process on the falling edge, inputs are stable there
  always @(negedge clk) begin
    if (cmp_en) check("rd_model", rd, expect_rd());
  end

  // driver tasks
  task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d);
    we = 1'b1; addr = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [W-1:0] a, input logic [W-1:0] exp);
    mem_read = 1'b1; addr = a;
    #1;
    check(name, rd, exp);
  endtask

  initial begin
    // power-up contents are zero without any reset
    #1;
    read_check("powerup_a0", 32'd0, 32'h0);
    read_check("powerup_a200", 32'd200, 32'h0);

    // one reset edge, then every address reads zero
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) read_check("reset_sweep", a, 32'h0);

    // basic write/read
    @(posedge clk); #1;
    do_write(32'd10, 32'hDEADBEEF);
    read_check("wr10_rd10", 32'd10, 32'hDEADBEEF);
    read_check("wr10_rd20", 32'd20, 32'h0);

    // MemRead gating is combinational
    mem_read = 1'b0; addr = 32'd10; #1;
    check("memread0", rd, 32'h0);
    mem_read = 1'b1; #1;
    check("memread1", rd, 32'hDEADBEEF);

    // simultaneous write and read: old before the edge, new after
    we = 1'b1; mem_read = 1'b1; addr = 32'd5; wd = 32'h12345678; #1;
    check("rw_before", rd, 32'h0);
    @(posedge clk); #1;
    we = 1'b0; #1;
    check("rw_after", rd, 32'h12345678);

    // aliasing through ignored upper bits
    do_write(32'd3, 32'hA5A5A5A5);
    read_check("alias_3pD", 32'd3 + DEPTH, 32'hA5A5A5A5);
    read_check("alias_hi", 32'hFFFF_FF03, 32'hA5A5A5A5);

    // reset wins over a simultaneous write and discards prior writes
    do_write(32'd7, 32'hCAFEF00D);
    read_check("pre_rst7", 32'd7, 32'hCAFEF00D);
    rst_n = 1'b0; we = 1'b1; addr = 32'd7; wd = 32'h1;
    @(posedge clk); #1;
    rst_n = 1'b1; we = 1'b0;
    read_check("rst_wr7", 32'd7, 32'h0);
    read_check("rst_clr10", 32'd10, 32'h0);
    do_write(32'd7, 32'h0000_0099);
    read_check("post_rst_wr", 32'd7, 32'h0000_0099);

    // randomized traffic checked by the compare process each cycle
    @(posedge clk); #1;
    cmp_en = 1'b1;
    repeat (3000) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      we       = $urandom_range(0, 1);
      mem_read = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0)
        addr = ($urandom() & 32'hFFFF_FF00) | W'($urandom_range(0, 15));
      else
        addr = $urandom();
      wd = $urandom();
      @(posedge clk); #1;
    end
    rst_n = 1'b1; we = 1'b0;

    // final sweep of the whole array after random traffic
    @(negedge clk);
    cmp_en = 1'b0;
    #1;
    for (int a = 0; a < DEPTH; a++) begin
      mem_read = 1'b1; addr = a; #1;
      check("final_sweep", rd, model[a]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
